// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch state encoding and address-width constants.
package cpu_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StHold
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory read port, decode handshake, redirect input, perf counter.
interface fetch_unit_if #(
    parameter int unsigned INSTR_W = 32
);
    import cpu_pkg::*;

    logic                imem_req;
    logic [ADDR_W-1:0]   imem_addr;
    logic                imem_ack;
    logic [INSTR_W-1:0]  imem_rdata;
    logic                instr_valid;
    logic                instr_ready;
    logic [INSTR_W-1:0]  instr;
    logic [ADDR_W-1:0]   instr_pc;
    logic                redirect_valid;
    logic [ADDR_W-1:0]   redirect_pc;
    logic [31:0]         perf_wait_cycles;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, perf_wait_cycles,
        input  imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, perf_wait_cycles,
        output imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/add_one.sv
// Combinational incrementer; wraps modulo 2**W.
module add_one #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);

    assign y = a + W'(1);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem read, instruction register, decode handshake, redirects.
// Optional wait-cycle counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned       INSTR_W  = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d, pc_plus_one;
    logic [ADDR_W-1:0]  pend_pc_q, pend_pc_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               pend_q, pend_d;
    logic               req_q, req_d;
    logic               valid_q, valid_d;

    add_one #(.W(ADDR_W)) u_pc_inc (.a(pc_q), .y(pc_plus_one));

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_pc_d  = pend_pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        req_d      = req_q;
        valid_d    = valid_q;
        case (state_q)
            StIdle: begin
                state_d = StFetch;
                req_d   = 1'b1;
                if (bus.redirect_valid) pc_d = bus.redirect_pc;
            end
            StFetch: begin
                if (!req_q) begin
                    // One-cycle gap after a discarded ack; PC is not yet on the bus
                    req_d = 1'b1;
                    if (bus.redirect_valid) pc_d = bus.redirect_pc;
                end else if (bus.imem_ack) begin
                    req_d = 1'b0;
                    if (pend_q || bus.redirect_valid) begin
                        pc_d   = bus.redirect_valid ? bus.redirect_pc : pend_pc_q;
                        pend_d = 1'b0;
                    end else begin
                        instr_d    = bus.imem_rdata;
                        instr_pc_d = pc_q;
                        valid_d    = 1'b1;
                        state_d    = StHold;
                    end
                end else if (bus.redirect_valid) begin
                    pend_d    = 1'b1;
                    pend_pc_d = bus.redirect_pc;
                end
            end
            StHold: begin
                if (valid_q && bus.instr_ready) begin
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    state_d = StFetch;
                    pc_d    = bus.redirect_valid ? bus.redirect_pc : pc_plus_one;
                end else if (bus.redirect_valid) begin
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    state_d = StFetch;
                    pc_d    = bus.redirect_pc;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            pend_q     <= 1'b0;
            pend_pc_q  <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_pc_q  <= pend_pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_q, perf_inc;

    add_one #(.W(32)) u_perf_inc (.a(perf_q), .y(perf_inc));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (req_q && !bus.imem_ack && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_inc;
        end
    end

    assign bus.perf_wait_cycles = perf_q;
`else
    assign bus.perf_wait_cycles = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then random traffic against a
// transaction-level reference model.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fetch_unit_if #(.INSTR_W(32)) bus ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .INSTR_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference model: what the fetch stage should be presenting right now
    logic        m_req, m_valid, m_pend;
    logic [31:0] m_addr, m_pend_pc, m_instr, m_ipc, m_perf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] exp_perf;
`ifdef FETCH_PERF_CNT_EN
        exp_perf = m_perf;
`else
        exp_perf = 32'h0;
`endif
        chk("imem_req", {31'b0, bus.imem_req}, {31'b0, m_req});
        chk("instr_valid", {31'b0, bus.instr_valid}, {31'b0, m_valid});
        chk("imem_addr", bus.imem_addr, m_addr);
        chk("instr", bus.instr, m_instr);
        chk("instr_pc", bus.instr_pc, m_ipc);
        chk("perf_wait_cycles", bus.perf_wait_cycles, exp_perf);
    endtask

    task automatic model_reset();
        m_req = 1'b0; m_valid = 1'b0; m_pend = 1'b0;
        m_addr = 32'h0; m_pend_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_perf = 32'h0;
    endtask

    task automatic do_reset(input logic ack_in_flight);
        rst_n = 1'b0;
        bus.imem_ack       = ack_in_flight && bus.imem_req;
        bus.imem_rdata     = 32'hBAD0_BAD0;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        bus.imem_ack = 1'b0;
        rst_n = 1'b1;
        model_reset();
    endtask

    // One clock: check outputs, drive inputs, advance, then apply the fetch rules
    task automatic step(input logic ack, input logic [31:0] rdata, input logic ready,
                        input logic redir, input logic [31:0] rpc);
        logic n_req, n_valid, ack_eff;
        check_all();
        ack_eff            = ack && bus.imem_req;
        bus.imem_ack       = ack_eff;
        bus.imem_rdata     = rdata;
        bus.instr_ready    = ready;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        @(posedge clk);
        n_req   = m_req;
        n_valid = m_valid;
        if (!m_req && !m_valid) begin
            if (redir) m_addr = rpc;
            n_req = 1'b1;
        end else if (m_req) begin
            if (!ack_eff) begin
                if (m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 32'd1;
                if (redir) begin
                    m_pend = 1'b1;
                    m_pend_pc = rpc;
                end
            end else begin
                n_req = 1'b0;
                if (m_pend || redir) begin
                    m_addr = redir ? rpc : m_pend_pc;
                    m_pend = 1'b0;
                end else begin
                    m_instr = rdata;
                    m_ipc   = m_addr;
                    n_valid = 1'b1;
                end
            end
        end else if (ready) begin
            n_valid = 1'b0;
            n_req   = 1'b1;
            m_addr  = redir ? rpc : m_addr + 32'd1;
        end else if (redir) begin
            n_valid = 1'b0;
            n_req   = 1'b1;
            m_addr  = rpc;
        end
        m_req   = n_req;
        m_valid = n_valid;
        #1;
    endtask

    task automatic fetch(input int waits, input logic [31:0] data);
        for (int i = 0; i < waits; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b1, data, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic accept();
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    endtask

    initial begin
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.instr_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        model_reset();
        do_reset(1'b0);

        // Reset release, two wait cycles, decoder ready
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("first_req", {31'b0, bus.imem_req}, 32'd1);
        chk("first_addr", bus.imem_addr, 32'h0);
        fetch(2, 32'hDEAD_0001);
        chk("first_instr", bus.instr, 32'hDEAD_0001);
        chk("first_instr_pc", bus.instr_pc, 32'h0);
        accept();
        chk("next_addr", bus.imem_addr, 32'h1);

        // Decoder stalls five cycles
        fetch(0, 32'h1234_5678);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("stall_instr", bus.instr, 32'h1234_5678);
        accept();

        // Redirect in HOLD without handshake
        fetch(1, 32'h0000_0B0B);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h40);
        chk("redir_hold_valid", {31'b0, bus.instr_valid}, 32'd0);
        chk("redir_hold_addr", bus.imem_addr, 32'h40);

        // Two redirects while a request to 5 waits; last one wins, data discarded
        fetch(0, 32'h0000_0C0C);
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h5);
        chk("addr5", bus.imem_addr, 32'h5);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h80);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h90);
        step(1'b1, 32'hFFFF_0005, 1'b0, 1'b0, 32'h0);
        chk("discard_valid", {31'b0, bus.instr_valid}, 32'd0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("refetch_addr", bus.imem_addr, 32'h90);

        // PC wrap
        fetch(0, 32'h0000_0090);
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFF);
        fetch(0, 32'h0000_FFFF);
        chk("wrap_instr_pc", bus.instr_pc, 32'hFFFF_FFFF);
        accept();
        chk("wrap_addr", bus.imem_addr, 32'h0);

        // Wait-cycle counter: 4 + 0 + 2
        do_reset(1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        fetch(4, 32'h1); accept();
        fetch(0, 32'h2); accept();
        fetch(2, 32'h3); accept();
`ifdef FETCH_PERF_CNT_EN
        chk("perf_total", bus.perf_wait_cycles, 32'd6);
`else
        chk("perf_total", bus.perf_wait_cycles, 32'd0);
`endif

        // Reset mid-transaction with an ack in flight
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        do_reset(1'b1);
        chk("midreset_req", {31'b0, bus.imem_req}, 32'd0);
        chk("midreset_addr", bus.imem_addr, 32'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) == 0, $urandom);
        end
        check_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
